// File: rtl/bidir_ram_reader_pkg.sv
// Shared constants and helpers for the RAM-to-stream reader.
package bidir_ram_reader_pkg;

  localparam int BUF_DEPTH = 2;

  // A word leaving the buffer this cycle frees its slot for a read issued now.
  function automatic logic has_room(input logic [1:0] occupancy,
                                    input logic [1:0] inflight,
                                    input logic       pop);
    logic [2:0] total;
    total = {1'b0, occupancy} + {1'b0, inflight} - {2'b00, pop};
    return total < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry output buffer: head register drives the stream, tail absorbs
// the word that arrives while the head is stalled.
module stream_skid2 #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             push_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       occupancy
);

  logic             tail_valid;
  logic [width-1:0] tail_data;
  logic             tail_last;
  logic             pop;

  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, out_valid} + {1'b0, tail_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        out_data <= tail_data;
        out_last <= tail_last;
        if (push) begin
          tail_data <= push_data;
          tail_last <= push_last;
        end else begin
          tail_valid <= 1'b0;
        end
      end else if (push) begin
        out_data <= push_data;
        out_last <= push_last;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= push_data;
        out_last  <= push_last;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= push_data;
        tail_last  <= push_last;
      end
    end
  end

endmodule

// File: rtl/bidir_ram_reader.sv
// Reads a run of consecutive RAM words through a registered-address read
// port and presents them as a valid/ready stream with a last marker.
module bidir_ram_reader
  import bidir_ram_reader_pkg::*;
#(
  parameter int width   = 1,
  parameter int widthad = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [widthad-1:0] cmd_addr,
  input  logic [widthad:0]   cmd_len,
  output logic [widthad-1:0] address_b,
  input  logic [width-1:0]   q_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    RUN   = S_RUN,
    DRAIN = S_DRAIN
  } state_t;

  state_t           state;
  logic [widthad:0] remaining;
  logic [1:0]       inflight;
  logic [1:0]       occupancy;
  logic             rd_pending;
  logic             pending_last;
  logic             pop;
  logic             issue;
  logic             issue_last;

  assign pop        = out_valid && out_ready;
  assign issue      = (state == RUN) && has_room(occupancy, inflight, pop);
  assign issue_last = issue && (remaining == (widthad+1)'(1));

  // address_b doubles as the read pointer: it only moves after a read of the
  // current address has been issued, so it parks on the last address used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      address_b    <= '0;
      remaining    <= '0;
      inflight     <= '0;
      rd_pending   <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      rd_pending   <= issue;
      pending_last <= issue_last;
      inflight     <= inflight + 2'(issue) - 2'(rd_pending);
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_len != '0) begin
            state     <= RUN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            address_b <= cmd_addr;
            remaining <= cmd_len;
          end
        end
        RUN: begin
          if (issue) begin
            remaining <= remaining - (widthad+1)'(1);
            if (issue_last) begin
              state <= DRAIN;
            end else begin
              address_b <= address_b + widthad'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  stream_skid2 #(
    .width(width)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending),
    .push_data (q_b),
    .push_last (pending_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_bidir_ram_reader.sv
// Bench for bidir_ram_reader: RAM model, scoreboard of expected words per
// command, table-driven directed commands and randomized commands.
module tb_bidir_ram_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [4:0] cmd_len;
  logic [3:0] address_b;
  logic [7:0] q_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  bidir_ram_reader #(.width(8), .widthad(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .address_b (address_b),
    .q_b       (q_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  logic [7:0] mem [16];
  always @(posedge clk) q_b <= mem[address_b];

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] len;
    int         mode;
    int         exp_words;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int words = 0;
  int valid_cycles = 0;
  int hs_cyc, first_valid_cyc, first_accept_cyc, last_accept_cyc;
  int ready_mode = 0;
  int pidx = 0;
  logic       checking = 1'b0;
  logic       hs_seen, done_seen;
  logic       model_busy = 1'b0;
  logic       stalled = 1'b0;
  logic [7:0] held_data, first_data, last_data;
  logic       held_last;
  logic [5:0] ready_pat = 6'b101001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a command becomes the list mem[addr], mem[addr+1]...
  // (addresses wrap at 16) with last marked on the final entry.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] a;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      model_busy = 1'b0;
      stalled = 1'b0;
    end else if (checking) begin
      chk("busy", busy, model_busy);
      chk("cmd_ready", cmd_ready, !model_busy);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_data);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        words++;
        if (first_accept_cyc < 0) begin
          first_accept_cyc = cyc;
          first_data = out_data;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e.d);
          chk("word_last", out_last, e.l);
          if (e.l) begin
            last_data = out_data;
            last_accept_cyc = cyc;
            done_seen = 1'b1;
            model_busy = 1'b0;
          end
        end
      end
      stalled = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (cmd_valid && cmd_ready) begin
        hs_seen = 1'b1;
        hs_cyc = cyc;
        if (cmd_len != 0) begin
          model_busy = 1'b1;
          for (int i = 0; i < int'(cmd_len); i++) begin
            a = cmd_addr + 4'(i);
            e.d = mem[a];
            e.l = (i == int'(cmd_len) - 1);
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pidx++;
    case (ready_mode)
      1: out_ready = ready_pat[pidx % 6];
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [4:0] l, input int mode);
    int budget;
    ready_mode = mode;
    pidx = 0;
    out_ready = (mode == 1) ? ready_pat[0] : 1'b1;
    hs_seen = 1'b0;
    done_seen = 1'b0;
    first_valid_cyc = -1;
    first_accept_cyc = -1;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    budget = 0;
    while (!hs_seen && budget < 50) begin
      tick();
      budget++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", hs_seen, 1);
    if (l != 0) begin
      budget = 0;
      while (!done_seen && budget < 400) begin
        tick();
        budget++;
      end
      chk("cmd_done", done_seen, 1);
    end
    repeat (3) tick();
    ready_mode = 0;
    out_ready = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v, input int words0, input int valid0);
    chk("word_count", words - words0, v.exp_words);
    if (v.exp_words > 0) begin
      chk("first_data", first_data, v.exp_first);
      chk("last_data", last_data, v.exp_last);
      chk("first_latency", first_valid_cyc - hs_cyc, 3);
      if (v.mode == 0) chk("sustained_rate", last_accept_cyc - first_accept_cyc, v.exp_words - 1);
    end else begin
      chk("no_valid", valid_cycles - valid0, 0);
    end
  endtask

  initial begin
    int w0, v0, budget;
    logic [3:0] ra;
    logic [4:0] rl;
    int rm;

    vecs[0] = '{4'd2,  5'd4,  0, 4,  8'h12, 8'h15};
    vecs[1] = '{4'd14, 5'd4,  0, 4,  8'h1E, 8'h11};
    vecs[2] = '{4'd5,  5'd4,  1, 4,  8'h15, 8'h18};
    vecs[3] = '{4'd0,  5'd0,  0, 0,  8'h00, 8'h00};
    vecs[4] = '{4'd0,  5'd16, 0, 16, 8'h10, 8'h1F};
    vecs[5] = '{4'd7,  5'd1,  0, 1,  8'h17, 8'h17};
    vecs[6] = '{4'd9,  5'd16, 2, 16, 8'h19, 8'h18};
    vecs[7] = '{4'd15, 5'd3,  1, 3,  8'h1F, 8'h11};

    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_address_b", address_b, 0);
    tick();
    rst_n = 1'b1;
    checking = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      w0 = words;
      v0 = valid_cycles;
      applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].mode);
      checkOutput(vecs[i], w0, v0);
    end

    // Reset after the second word of an 8-word command.
    w0 = words;
    ready_mode = 0;
    hs_seen = 1'b0;
    cmd_addr = 4'd4;
    cmd_len = 5'd8;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    budget = 0;
    while (words - w0 < 2 && budget < 50) begin
      tick();
      budget++;
    end
    chk("rst_mid_two_words", words - w0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    w0 = words;
    v0 = valid_cycles;
    repeat (10) tick();
    chk("rst_mid_no_words", valid_cycles - v0, 0);
    w0 = words;
    applyStimulus(4'd3, 5'd5, 0);
    chk("post_rst_words", words - w0, 5);
    chk("post_rst_last", last_data, 8'h17);

    // Back-to-back commands with cmd_valid held high throughout.
    w0 = words;
    hs_seen = 1'b0;
    done_seen = 1'b0;
    last_accept_cyc = -1;
    cmd_addr = 4'd1;
    cmd_len = 5'd3;
    cmd_valid = 1'b1;
    budget = 0;
    while (!hs_seen && budget < 50) begin
      tick();
      budget++;
    end
    hs_seen = 1'b0;
    cmd_addr = 4'd8;
    cmd_len = 5'd2;
    budget = 0;
    while (!hs_seen && budget < 50) begin
      tick();
      budget++;
    end
    cmd_valid = 1'b0;
    chk("b2b_second_accepted", hs_seen, 1);
    chk("b2b_first_done", done_seen, 1);
    chk("b2b_gap", hs_cyc > last_accept_cyc, 1);
    done_seen = 1'b0;
    budget = 0;
    while (!done_seen && budget < 50) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    chk("b2b_words", words - w0, 5);

    // Randomized commands over random RAM contents and random stalls.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 12; n++) begin
      ra = 4'($urandom_range(0, 15));
      rl = 5'($urandom_range(0, 16));
      rm = $urandom_range(0, 2);
      w0 = words;
      applyStimulus(ra, rl, rm);
      chk("rand_words", words - w0, int'(rl));
      if (rl != 0) chk("rand_latency", first_valid_cyc - hs_cyc, 3);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
